// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC and issues one text-memory fetch per cycle
// under a credit limit. Responses arrive after a fixed latency and are buffered for decode.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0040_0000,
  parameter logic [31:0] TEXT_BEGIN   = 32'h0040_0000,
  parameter logic [31:0] TEXT_END     = 32'h0040_FFFF,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_read_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        instr_fault
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LAST  = READ_LATENCY - 1;

  typedef enum logic {ST_FETCH = 1'b0, ST_HALT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;

  logic             tag_valid_q [READ_LATENCY];
  logic             tag_valid_d [READ_LATENCY];
  logic [31:0]      tag_pc_q    [READ_LATENCY];
  logic [31:0]      tag_pc_d    [READ_LATENCY];
  logic             tag_fault_q [READ_LATENCY];
  logic             tag_fault_d [READ_LATENCY];

  logic [31:0]      fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]      fifo_data_q  [FIFO_DEPTH];
  logic             fifo_fault_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0]      inflight;
  logic [31:0]      occupancy;
  logic             addr_legal;
  logic             pop;
  logic             push;
  logic             issue;
  logic [31:0]      push_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        tag_valid_q[i] <= 1'b0;
        tag_pc_q[i]    <= '0;
        tag_fault_q[i] <= 1'b0;
      end
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        tag_valid_q[i] <= tag_valid_d[i];
        tag_pc_q[i]    <= tag_pc_d[i];
        tag_fault_q[i] <= tag_fault_d[i];
      end
    end
  end

  // Entry storage needs no reset: the count gates every read.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= tag_pc_q[LAST];
      fifo_data_q[wr_ptr_q]  <= push_data;
      fifo_fault_q[wr_ptr_q] <= tag_fault_q[LAST];
    end
  end

  // Next-state and datapath
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(READ_LATENCY); i++) begin
      inflight = inflight + 32'(tag_valid_q[i]);
    end
    pop        = instr_valid & instr_ready;
    occupancy  = 32'(count_q) + inflight - 32'(pop);
    addr_legal = (mem_address[1:0] == 2'b00) &&
                 (mem_address >= TEXT_BEGIN) && (mem_address <= TEXT_END);
    // A redirect flushes everything, so it always has credit.
    issue      = redirect_valid || ((state_q == ST_FETCH) && (occupancy < FIFO_DEPTH));

    state_d = state_q;
    pc_d    = pc_q;
    if (issue) begin
      state_d = addr_legal ? ST_FETCH : ST_HALT;
      if (addr_legal) begin
        pc_d = mem_address + 32'd4;
      end
    end

    for (int i = 0; i < int'(READ_LATENCY); i++) begin
      if (i == 0) begin
        tag_valid_d[i] = issue;
        tag_pc_d[i]    = mem_address;
        tag_fault_d[i] = !addr_legal;
      end else begin
        tag_valid_d[i] = tag_valid_q[i-1] && !redirect_valid;
        tag_pc_d[i]    = tag_pc_q[i-1];
        tag_fault_d[i] = tag_fault_q[i-1];
      end
    end

    push      = tag_valid_q[LAST] && !redirect_valid;
    push_data = tag_fault_q[LAST] ? '0 : mem_read_data;

    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Outputs
  always_comb begin
    mem_address = redirect_valid ? redirect_pc : pc_q;
    instr_valid = (count_q != '0);
    instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q]    : '0;
    instr_data  = instr_valid ? fifo_data_q[rd_ptr_q]  : '0;
    instr_fault = instr_valid ? fifo_fault_q[rd_ptr_q] : 1'b0;
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed sequences, a redirect vector table,
// and randomized traffic checked against a program-order stream model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] T_BEGIN  = 32'h0040_0000;
  localparam logic [31:0] T_END    = 32'h0040_FFFF;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] mem_address;
  logic [31:0] mem_read_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_fault;

  instruction_fetch_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .mem_address    (mem_address),
    .mem_read_data  (mem_read_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_fault    (instr_fault)
  );

  always #5 clock = ~clock;

  // Text memory: one-cycle read latency, contents derived from the address.
  always @(posedge clock) mem_read_data <= mem_address ^ KEY;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_pop = 0;
  logic [31:0] exp_pc = RESET_PC;
  bit          exp_done = 1'b0;
  bit          prev_rv = 1'b0;

  typedef struct {
    logic [31:0] target;
    logic [31:0] pc;
    logic [31:0] data;
    logic        fault;
  } vec_t;
  vec_t vecs [8];

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= T_BEGIN) && (a <= T_END);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // One cycle: apply inputs at the falling edge, score any pop the next rising edge takes.
  task automatic drive(input bit rdy, input bit rv, input logic [31:0] rpc);
    @(negedge clock);
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    if (prev_rv) check("valid_after_redirect", instr_valid, 1'b0);
    if (instr_valid && instr_ready) begin
      n_pop++;
      check("stream_not_ended", exp_done, 1'b0);
      if (!exp_done) begin
        check("model_entry", {instr_pc, instr_data, instr_fault},
              {exp_pc, legal(exp_pc) ? (exp_pc ^ KEY) : 32'h0, !legal(exp_pc)});
        if (legal(exp_pc)) exp_pc = exp_pc + 32'd4;
        else exp_done = 1'b1;
      end
    end
    if (rv) begin
      exp_pc   = rpc;
      exp_done = 1'b0;
    end
    prev_rv = rv;
  endtask

  task automatic expect_head(input string name, input logic [31:0] pc,
                             input logic [31:0] data, input logic fault);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      if (instr_valid) begin
        found = 1'b1;
        check(name, {instr_pc, instr_data, instr_fault}, {pc, data, fault});
      end
    end
    check({name, "_seen"}, found, 1'b1);
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("reset_outputs", {instr_valid, instr_fault, instr_data, instr_pc, mem_address},
          {1'b0, 1'b0, 32'h0, 32'h0, RESET_PC});
    @(negedge clock);
    reset_n  = 1'b1;
    exp_pc   = RESET_PC;
    exp_done = 1'b0;
    prev_rv  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  initial begin
    int pops_before;
    bit          rr, rv;
    logic [31:0] tgt;
    int          sel;

    vecs[0] = '{32'h0040_0100, 32'h0040_0100, 32'hA5E5_0100, 1'b0};
    vecs[1] = '{32'h0040_0102, 32'h0040_0102, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h003F_FFFC, 32'h003F_FFFC, 32'h0000_0000, 1'b1};
    vecs[3] = '{32'h0040_FFFC, 32'h0040_FFFC, 32'hA5E5_FFFC, 1'b0};
    vecs[4] = '{32'h0041_0000, 32'h0041_0000, 32'h0000_0000, 1'b1};
    vecs[5] = '{32'h0040_0001, 32'h0040_0001, 32'h0000_0000, 1'b1};
    vecs[6] = '{32'h0040_0800, 32'h0040_0800, 32'hA5E5_0800, 1'b0};
    vecs[7] = '{32'h0040_8004, 32'h0040_8004, 32'hA5E5_8004, 1'b0};

    // Reset, first-entry latency and one fetch per cycle
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      check("t1_fetch_addr", mem_address, RESET_PC + 32'(4 * i));
      check("t1_valid", instr_valid, (i >= 2));
      if (i == 2) check("t1_first_entry", {instr_pc, instr_data}, {RESET_PC, 32'hA5E5_0000});
    end

    // Decode stall: head holds, fetch stops two words ahead
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      check("t2_head_stable", {instr_valid, instr_pc, instr_data, instr_fault},
            {1'b1, exp_pc, exp_pc ^ KEY, 1'b0});
      check("t2_issue_stalled", mem_address, exp_pc + 32'd8);
    end
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 32'h0);

    // Redirect while full, then redirect with a pop in the same cycle
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 32'h0040_0100);
    drive(1'b0, 1'b0, 32'h0);
    expect_head("t3_after_redirect", 32'h0040_0100, 32'hA5E5_0100, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 32'h0040_0200);
    expect_head("t3_redirect_with_pop", 32'h0040_0200, 32'hA5E5_0200, 1'b0);

    // Misaligned redirect faults and halts until the next redirect
    drive(1'b1, 1'b1, 32'h0040_0102);
    expect_head("t4_fault_entry", 32'h0040_0102, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      check("t4_halt_no_entry", instr_valid, 1'b0);
    end
    drive(1'b1, 1'b1, RESET_PC);
    expect_head("t4_resume", RESET_PC, 32'hA5E5_0000, 1'b0);

    // Running off the end of text
    drive(1'b1, 1'b1, 32'h0040_FFF8);
    expect_head("t5_entry_fff8", 32'h0040_FFF8, 32'hA5E5_FFF8, 1'b0);
    expect_head("t5_entry_fffc", 32'h0040_FFFC, 32'hA5E5_FFFC, 1'b0);
    expect_head("t5_fault_end", 32'h0041_0000, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      check("t5_halted", {instr_valid, mem_address}, {1'b0, 32'h0041_0000});
    end

    // Asynchronous reset mid-cycle with the buffer full
    drive(1'b1, 1'b1, RESET_PC);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 32'h0);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_flush", {instr_valid, instr_pc, instr_data, mem_address},
          {1'b0, 32'h0, 32'h0, RESET_PC});
    exp_pc         = RESET_PC;
    exp_done       = 1'b0;
    prev_rv        = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    expect_head("t6_first_after_reset", RESET_PC, 32'hA5E5_0000, 1'b0);

    // Redirect vector table
    for (int v = 0; v < 8; v++) begin
      drive(1'b1, 1'b1, vecs[v].target);
      expect_head($sformatf("vec%0d_head", v), vecs[v].pc, vecs[v].data, vecs[v].fault);
      drive(1'b1, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 32'h0);
    end

    // Randomized traffic against the stream model
    pops_before = n_pop;
    for (int c = 0; c < 1500; c++) begin
      rr  = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      sel = $urandom_range(0, 7);
      tgt = T_BEGIN + (32'($urandom_range(0, 16383)) << 2);
      if (sel == 5) tgt = 32'h0040_FFF0 + (32'($urandom_range(0, 3)) << 2);
      else if (sel == 6) tgt = tgt | 32'($urandom_range(1, 3));
      else if (sel == 7) tgt = ($urandom_range(0, 1) != 0) ? 32'h0041_0000 + (32'($urandom_range(0, 255)) << 2)
                                                            : 32'h003F_FF00;
      drive(rr, rv, tgt);
    end
    check("rand_liveness", (n_pop - pops_before) > 300, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
